rv32i_id_stage: RTL and testbench
=================================

// Module: rv32i_id_stage
// PURPOSE
// - RV32I decode stage: decodes i_instr, reads 32x32 regfile, generates immediate, registers ALU-side fields into ID/EX.
// - Producer of ALU inputs (opcode/funct3/funct7/rs1_data/rs2_data/imm); sits between IF and EX.
// - Valid/ready handshake both sides; load-use interlock, flush, WB write-through bypass.
// PARAMETERS
// - WIDTH  32  datapath/register width (only 32 supported)
// - NREGS  32  architectural register count (x0 hardwired 0)
// PORTS
// - clk         in   1      clock
// - rst         in   1      synchronous active-high reset
// - i_if_valid  in   1      IF presents instruction
// - o_if_ready  out  1      stage accepts instruction this cycle
// - i_instr     in   32     instruction word
// - i_pc        in   WIDTH  instruction PC
// - i_wb_we     in   1      WB writes regfile
// - i_wb_rd     in   5      WB destination
// - i_wb_data   in   WIDTH  WB data
// - i_ex_ready  in   1      EX accepts ID/EX contents
// - i_flush     in   1      kill ID/EX contents (branch/jump redirect)
// - o_valid     out  1      ID/EX holds a valid instruction
// - o_opcode    out  7      instr[6:0]
// - o_funct3    out  3      instr[14:12]
// - o_funct7    out  7      instr[31:25] for OP and OP-IMM shifts (f3 001/101); else 0
// - o_rs1_data  out  WIDTH  rs1 value (bypassed)
// - o_rs2_data  out  WIDTH  rs2 value (bypassed)
// - o_imm       out  WIDTH  sign-extended immediate
// - o_pc        out  WIDTH  PC of instruction
// - o_rd        out  5      destination
// - o_rd_we     out  1      writes rd (0 if rd==x0 or illegal)
// - o_is_load   out  1      LOAD opcode
// - o_illegal   out  1      unsupported encoding
// BEHAVIOUR
// - Reset: o_valid=0, all ID/EX outputs 0, all regfile entries 0; o_if_ready=1 after reset.
// - Latency 1: accepted (i_if_valid&&o_if_ready) at edge N -> outputs valid after edge N.
// - load_use = o_valid&&o_is_load&&o_rd!=0 && (rs1 used&&rs1==o_rd || rs2 used&&rs2==o_rd).
//   rs1 used: OP,OP-IMM,LOAD,STORE,BRANCH,JALR; rs2 used: OP,STORE,BRANCH.
// - o_if_ready = !i_flush && !load_use && (i_ex_ready || !o_valid) (combinational).
// - Per edge, priority: rst > i_flush (o_valid<=0) > advance (i_ex_ready||!o_valid):
//   load decoded fields if accept, else o_valid<=0 (bubble); otherwise hold all outputs.
// - Flush with i_if_valid same cycle: instruction not accepted (ready=0), ID/EX cleared.
// - Regfile: write at edge when i_wb_we&&i_wb_rd!=0; x0 reads 0.
//   Read bypass: i_wb_we&&i_wb_rd==rsN&&rsN!=0 -> rsN_data=i_wb_data same cycle.
// - Immediates: I (LOAD,OP-IMM,JALR) {20{i[31]},i[31:20]}; S {i[31:25],i[11:7]};
//   B {i[31],i[7],i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {i[31],i[19:12],i[20],i[30:21],0}; OP: 0.
// - Legal opcodes: 0110111,0010111,1101111,1100111,1100011,0000011,0100011,0010011,0110011; else illegal.
// - OP funct7: 0000000 any f3; 0100000 only f3 000/101; 0000001 see config; else illegal.
// - OP-IMM: f3 001 needs f7=0000000; f3 101 needs f7 0000000/0100000; else illegal.
// - o_rd_we=1 for LUI,AUIPC,JAL,JALR,LOAD,OP-IMM,OP when rd!=0 and not illegal.
// - Illegal instr still advances with o_valid=1, o_illegal=1, o_rd_we=0.
// CONFIGURATION
// - RV32M_EN defined: OP with funct7=0000001 (MUL..REMU, all f3) legal, decoded as OP.
// - RV32M_EN undefined: funct7=0000001 on OP -> o_illegal=1, o_rd_we=0.
// TESTING
// - Reset 2 cycles -> o_valid=0, all outputs 0, o_if_ready=1.
// - WB x5=5,x6=3; issue 0x006283B3 (add x7,x5,x6) -> next: op=0110011,f3=0,f7=0,rs1=5,rs2=3,imm=0,rd=7,rd_we=1.
// - Issue 0xF9C28413 (addi x8,x5,-100) -> imm=0xFFFFFF9C, f7=0, rs1=5; same cycle WB x5=0x1234 -> rs1=0x1234.
// - 0x0002A503 (lw x10,0(x5)) then 0x006505B3 (add x11,x10,x6) -> ready=0 one cycle, o_valid=0 bubble, add next.
// - i_ex_ready=0 3 cycles -> outputs held, ready=0; i_flush=1 -> o_valid=0 next edge, input not consumed.
// - 0x02628433 (mul x8,x5,x6): RV32M_EN -> legal,f7=0000001,rd_we=1; without -> illegal=1,rd_we=0.

Source files
------------

// File: rtl/rv32i_id_stage.sv
// RV32I decode stage: field decode, 32x32 regfile with WB write-through bypass, immediate
// generation, load-use interlock and ID/EX register. Define RV32M_EN to accept OP funct7=0000001.
module rv32i_id_stage #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_if_valid,
  output logic             o_if_ready,
  input  logic [31:0]      i_instr,
  input  logic [WIDTH-1:0] i_pc,
  input  logic             i_wb_we,
  input  logic [4:0]       i_wb_rd,
  input  logic [WIDTH-1:0] i_wb_data,
  input  logic             i_ex_ready,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [6:0]       o_opcode,
  output logic [2:0]       o_funct3,
  output logic [6:0]       o_funct7,
  output logic [WIDTH-1:0] o_rs1_data,
  output logic [WIDTH-1:0] o_rs2_data,
  output logic [WIDTH-1:0] o_imm,
  output logic [WIDTH-1:0] o_pc,
  output logic [4:0]       o_rd,
  output logic             o_rd_we,
  output logic             o_is_load,
  output logic             o_illegal
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  opcode_e    opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = opcode_e'(i_instr[6:0]);
  assign rd  = i_instr[11:7];
  assign f3  = i_instr[14:12];
  assign rs1 = i_instr[19:15];
  assign rs2 = i_instr[24:20];
  assign f7  = i_instr[31:25];

  // Decode of the instruction presented by IF.
  logic             rs1_used, rs2_used, writes_rd, illegal_d;
  logic [6:0]       f7_d;
  logic [WIDTH-1:0] imm_d;

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    illegal_d = 1'b0;
    f7_d      = '0;
    imm_d     = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        imm_d     = {i_instr[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        imm_d     = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OPC_JALR, OPC_LOAD: begin
        imm_d     = {{20{i_instr[31]}}, i_instr[31:20]};
        rs1_used  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        imm_d    = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_STORE: begin
        imm_d    = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_OPIMM: begin
        imm_d     = {{20{i_instr[31]}}, i_instr[31:20]};
        rs1_used  = 1'b1;
        writes_rd = 1'b1;
        // Shift-immediates carry funct7 in the upper immediate bits.
        if (f3 == 3'b001) begin
          f7_d      = f7;
          illegal_d = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          f7_d      = f7;
          illegal_d = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        end
      end
      OPC_OP: begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        writes_rd = 1'b1;
        f7_d      = f7;
        case (f7)
          7'b0000000: illegal_d = 1'b0;
          7'b0100000: illegal_d = (f3 != 3'b000) && (f3 != 3'b101);
`ifdef RV32M_EN
          7'b0000001: illegal_d = 1'b0;
`else
          7'b0000001: illegal_d = 1'b1;
`endif
          default:    illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Register file; x0 is never written and always reads zero.
  logic [WIDTH-1:0] regs [NREGS];

  // NOTE: the array is cleared on reset so x1..x31 read zero afterwards; this keeps it in flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (i_wb_we && i_wb_rd != 5'd0) begin
      regs[i_wb_rd] <= i_wb_data;
    end
  end

  // A same-cycle WB write is forwarded so the ID/EX copy is never stale.
  logic [WIDTH-1:0] rs1_data_d, rs2_data_d;
  assign rs1_data_d = (rs1 == 5'd0) ? '0 :
                      (i_wb_we && i_wb_rd == rs1) ? i_wb_data : regs[rs1];
  assign rs2_data_d = (rs2 == 5'd0) ? '0 :
                      (i_wb_we && i_wb_rd == rs2) ? i_wb_data : regs[rs2];

  // Handshake: a load in ID/EX cannot forward to the instruction right behind it.
  logic load_use, advance, accept;
  assign load_use   = o_valid && o_is_load && (o_rd != 5'd0) &&
                      ((rs1_used && rs1 == o_rd) || (rs2_used && rs2 == o_rd));
  assign advance    = i_ex_ready || !o_valid;
  assign o_if_ready = !i_flush && !load_use && advance;
  assign accept     = i_if_valid && o_if_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_opcode   <= '0;
      o_funct3   <= '0;
      o_funct7   <= '0;
      o_rs1_data <= '0;
      o_rs2_data <= '0;
      o_imm      <= '0;
      o_pc       <= '0;
      o_rd       <= '0;
      o_rd_we    <= 1'b0;
      o_is_load  <= 1'b0;
      o_illegal  <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (advance) begin
      if (accept) begin
        o_valid    <= 1'b1;
        o_opcode   <= i_instr[6:0];
        o_funct3   <= f3;
        o_funct7   <= f7_d;
        o_rs1_data <= rs1_data_d;
        o_rs2_data <= rs2_data_d;
        o_imm      <= imm_d;
        o_pc       <= i_pc;
        o_rd       <= rd;
        o_rd_we    <= writes_rd && !illegal_d && (rd != 5'd0);
        o_is_load  <= (opc == OPC_LOAD);
        o_illegal  <= illegal_d;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_id_stage.sv
// Bench for rv32i_id_stage: directed literal checks, then randomized traffic against an
// instruction-level reference model of the decode stage.
module tb_rv32i_id_stage;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BRANCH = 7'h63;
  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, i_if_valid, o_if_ready, i_wb_we, i_ex_ready, i_flush;
  logic [31:0] i_instr, i_pc, i_wb_data;
  logic [4:0]  i_wb_rd;
  logic        o_valid, o_rd_we, o_is_load, o_illegal;
  logic [6:0]  o_opcode, o_funct7;
  logic [2:0]  o_funct3;
  logic [31:0] o_rs1_data, o_rs2_data, o_imm, o_pc;
  logic [4:0]  o_rd;

  rv32i_id_stage dut (
    .clk(clk), .rst(rst), .i_if_valid(i_if_valid), .o_if_ready(o_if_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd),
    .i_wb_data(i_wb_data), .i_ex_ready(i_ex_ready), .i_flush(i_flush),
    .o_valid(o_valid), .o_opcode(o_opcode), .o_funct3(o_funct3), .o_funct7(o_funct7),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_pc(o_pc),
    .o_rd(o_rd), .o_rd_we(o_rd_we), .o_is_load(o_is_load), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1d, rs2d, imm, pc;
    logic [4:0]  rd;
    logic        rd_we, is_load, illegal;
  } idex_t;

  idex_t       m;
  logic [31:0] mregs [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (i_wb_we && i_wb_rd == idx) return i_wb_data;
    return mregs[idx];
  endfunction

  function automatic idex_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    idex_t       d;
    logic [6:0]  op;
    int          f3, f7;
    logic [31:0] sext;
    op   = ins[6:0];
    f3   = int'(ins[14:12]);
    f7   = int'(ins[31:25]);
    sext = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    d = '0;
    d.valid   = 1'b1;
    d.opcode  = op;
    d.f3      = ins[14:12];
    d.pc      = pc;
    d.rd      = ins[11:7];
    d.rs1d    = model_read(ins[19:15]);
    d.rs2d    = model_read(ins[24:20]);
    d.is_load = (op == LOAD);
    d.illegal = !(op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP});
    if (op == OP)
      d.illegal = !((f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)) || (f7 == 1 && M_EN));
    if (op == OPIMM && f3 == 1) d.illegal = (f7 != 0);
    if (op == OPIMM && f3 == 5) d.illegal = !(f7 == 0 || f7 == 32);
    if (op == OP || (op == OPIMM && (f3 == 1 || f3 == 5))) d.f7 = ins[31:25];
    if (op inside {LOAD, OPIMM, JALR})
      d.imm = (sext & 32'hFFFF_F800) | 32'(ins[30:20]);
    else if (op == STORE)
      d.imm = (sext & 32'hFFFF_F800) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]);
    else if (op == BRANCH)
      d.imm = (sext & 32'hFFFF_F000) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) |
              (32'(ins[11:8]) << 1);
    else if (op == LUI || op == AUIPC)
      d.imm = ins & 32'hFFFF_F000;
    else if (op == JAL)
      d.imm = (sext & 32'hFFF0_0000) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) |
              (32'(ins[30:21]) << 1);
    d.rd_we = (op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP}) && d.rd != 0 && !d.illegal;
    return d;
  endfunction

  function automatic logic model_ready();
    logic [6:0] op;
    logic       u1, u2, lu;
    op = i_instr[6:0];
    u1 = op inside {OP, OPIMM, LOAD, STORE, BRANCH, JALR};
    u2 = op inside {OP, STORE, BRANCH};
    lu = m.valid && m.is_load && m.rd != 0 &&
         ((u1 && i_instr[19:15] == m.rd) || (u2 && i_instr[24:20] == m.rd));
    return !i_flush && !lu && (i_ex_ready || !m.valid);
  endfunction

  task automatic compare();
    check("valid", o_valid, m.valid);
    if (m.valid) begin
      check("opcode", o_opcode, m.opcode);
      check("funct3", o_funct3, m.f3);
      check("funct7", o_funct7, m.f7);
      check("rs1_data", o_rs1_data, m.rs1d);
      check("rs2_data", o_rs2_data, m.rs2d);
      check("imm", o_imm, m.imm);
      check("pc", o_pc, m.pc);
      check("rd", o_rd, m.rd);
      check("rd_we", o_rd_we, m.rd_we);
      check("is_load", o_is_load, m.is_load);
      check("illegal", o_illegal, m.illegal);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    idex_t nxt;
    logic  rdy;
    #1;
    rdy = model_ready();
    check("if_ready", o_if_ready, rdy);
    nxt = m;
    if (rst) nxt = '0;
    else if (i_flush) nxt.valid = 1'b0;
    else if (i_ex_ready || !m.valid) begin
      if (i_if_valid && rdy) nxt = model_decode(i_instr, i_pc);
      else nxt.valid = 1'b0;
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (i_wb_we && i_wb_rd != 0) begin
      mregs[i_wb_rd] = i_wb_data;
    end
    m = nxt;
    @(negedge clk);
    compare();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins        = $urandom;
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 12))
      0:       ins[6:0] = LUI;
      1:       ins[6:0] = AUIPC;
      2:       ins[6:0] = JAL;
      3:       ins[6:0] = JALR;
      4:       ins[6:0] = BRANCH;
      5:       ins[6:0] = STORE;
      6, 7:    ins[6:0] = OPIMM;
      8, 9:    ins[6:0] = LOAD;
      10, 11:  ins[6:0] = OP;
      default: ;
    endcase
    if (ins[6:0] == OP || ins[6:0] == OPIMM) begin
      case ($urandom_range(0, 3))
        0:       ins[31:25] = 7'h00;
        1:       ins[31:25] = 7'h20;
        2:       ins[31:25] = 7'h01;
        default: ;
      endcase
    end
    return ins;
  endfunction

  initial begin
    rst = 1'b1; i_if_valid = 1'b0; i_instr = 32'd0; i_pc = 32'd0;
    i_wb_we = 1'b0; i_wb_rd = 5'd0; i_wb_data = 32'd0; i_ex_ready = 1'b1; i_flush = 1'b0;
    m = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_opcode", o_opcode, 0);
    check("rst_imm", o_imm, 0);
    check("rst_rd_we", o_rd_we, 0);
    check("rst_illegal", o_illegal, 0);
    check("rst_ready", o_if_ready, 1);
    rst = 1'b0;

    // Write x5=5, x6=3.
    i_wb_we = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'd5; step();
    i_wb_rd = 5'd6; i_wb_data = 32'd3; step();
    i_wb_we = 1'b0;

    // add x7,x5,x6
    i_if_valid = 1'b1; i_instr = 32'h0062_83B3; i_pc = 32'h100; step();
    check("add_valid", o_valid, 1);
    check("add_opcode", o_opcode, 7'h33);
    check("add_f7", o_funct7, 0);
    check("add_rs1", o_rs1_data, 5);
    check("add_rs2", o_rs2_data, 3);
    check("add_imm", o_imm, 0);
    check("add_rd", o_rd, 7);
    check("add_rd_we", o_rd_we, 1);

    // addi x8,x5,-100 with same-cycle WB of x5
    i_instr = 32'hF9C2_8413; i_pc = 32'h104;
    i_wb_we = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h1234; step();
    i_wb_we = 1'b0;
    check("addi_imm", o_imm, 32'hFFFF_FF9C);
    check("addi_rs1_bypass", o_rs1_data, 32'h1234);
    check("addi_f7", o_funct7, 0);

    // lw x10,0(x5) then add x11,x10,x6 -> one bubble
    i_instr = 32'h0002_A503; i_pc = 32'h108; step();
    check("lw_is_load", o_is_load, 1);
    i_instr = 32'h0065_05B3; i_pc = 32'h10C;
    #1 check("lu_ready", o_if_ready, 0);
    step();
    check("lu_bubble", o_valid, 0);
    step();
    check("lu_add_valid", o_valid, 1);
    check("lu_add_rd", o_rd, 11);

    // EX stall for three cycles, then flush with an instruction presented.
    i_instr = 32'h0010_0493; i_pc = 32'h110; i_ex_ready = 1'b0;
    repeat (3) begin
      #1 check("stall_ready", o_if_ready, 0);
      step();
      check("stall_hold_rd", o_rd, 11);
      check("stall_hold_valid", o_valid, 1);
    end
    i_flush = 1'b1;
    #1 check("flush_ready", o_if_ready, 0);
    step();
    check("flush_valid", o_valid, 0);
    i_flush = 1'b0; i_ex_ready = 1'b1; step();
    check("after_flush_rd", o_rd, 9);
    check("after_flush_imm", o_imm, 1);

    // mul x8,x5,x6
    i_instr = 32'h0262_8433; i_pc = 32'h114; step();
    check("mul_f7", o_funct7, 7'h01);
    check("mul_illegal", o_illegal, M_EN ? 32'd0 : 32'd1);
    check("mul_rd_we", o_rd_we, M_EN ? 32'd1 : 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 499) == 0);
      i_if_valid = ($urandom_range(0, 4) != 0);
      i_instr    = rand_instr();
      i_pc       = $urandom;
      i_wb_we    = $urandom_range(0, 1) == 1;
      i_wb_rd    = 5'($urandom_range(0, 7));
      i_wb_data  = $urandom;
      i_ex_ready = ($urandom_range(0, 3) != 0);
      i_flush    = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
